// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the E/M/W hazard scoreboard and its match units.
package hazard_scoreboard_pkg;

  localparam int SB_REG_AW    = 5;
  localparam int SB_TW        = 2;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [SB_REG_AW-1:0] waddr;
    logic [SB_TW-1:0]     tnew;
  } slot_t;

  function automatic logic slot_hits(slot_t s, logic [SB_REG_AW-1:0] src);
    return s.valid && (s.waddr != '0) && (s.waddr == src);
  endfunction

  // One stage of ageing: the remaining latency counts down and sticks at zero.
  function automatic slot_t slot_age(slot_t s);
    slot_t r;
    r = s;
    if (s.tnew != '0) r.tnew = s.tnew - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest E/M/W slot writing a given source register and reports its remaining Tnew.
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [SB_REG_AW-1:0] src,
  input  slot_t                e_slot,
  input  slot_t                m_slot,
  input  slot_t                w_slot,
  output logic [1:0]           hit_stage,
  output logic [SB_TW-1:0]     hit_tnew
);

  // Later assignments win, so the youngest matching stage has the final say.
  always_comb begin
    hit_stage = FWD_RF;
    hit_tnew  = '0;
    if (slot_hits(w_slot, src)) begin
      hit_stage = FWD_W;
      hit_tnew  = w_slot.tnew;
    end
    if (slot_hits(m_slot, src)) begin
      hit_stage = FWD_M;
      hit_tnew  = m_slot.tnew;
    end
    if (slot_hits(e_slot, src)) begin
      hit_stage = FWD_E;
      hit_tnew  = e_slot.tnew;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: D-stage stall, D/E/M forwarding selects and HI/LO busy tracking.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = SB_REG_AW,
  parameter int TW       = SB_TW,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CW       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_waddr,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              d_md_start,
  input  logic              d_md_div,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt,
  output logic              md_busy
);

  slot_t             e_q, e_d, m_q, m_d, w_q, w_d;
  logic [REG_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, m_rt_q, m_rt_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  slot_t             slot_none;
  slot_t             m_ready;
  logic [1:0]        d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit;
  logic [TW-1:0]     d_rs_tnew, d_rt_tnew, e_rs_tnew, e_rt_tnew;
  logic              rs_late, rt_late;

  assign slot_none = '0;

  // E consumers may only take M once its result exists; otherwise W is the next candidate.
  always_comb begin
    m_ready       = m_q;
    m_ready.valid = m_q.valid && (m_q.tnew == '0);
  end

  hazard_match u_d_rs (.src(d_rs),   .e_slot(e_q),       .m_slot(m_q),     .w_slot(w_q),
                       .hit_stage(d_rs_hit), .hit_tnew(d_rs_tnew));
  hazard_match u_d_rt (.src(d_rt),   .e_slot(e_q),       .m_slot(m_q),     .w_slot(w_q),
                       .hit_stage(d_rt_hit), .hit_tnew(d_rt_tnew));
  hazard_match u_e_rs (.src(e_rs_q), .e_slot(slot_none), .m_slot(m_ready), .w_slot(w_q),
                       .hit_stage(e_rs_hit), .hit_tnew(e_rs_tnew));
  hazard_match u_e_rt (.src(e_rt_q), .e_slot(slot_none), .m_slot(m_ready), .w_slot(w_q),
                       .hit_stage(e_rt_hit), .hit_tnew(e_rt_tnew));

  always_comb begin
    md_busy  = (cnt_q != '0);
    rs_late  = (d_tuse_rs != TUSE_NONE) && (d_rs_hit != FWD_RF) && (d_rs_tnew > d_tuse_rs);
    rt_late  = (d_tuse_rt != TUSE_NONE) && (d_rt_hit != FWD_RF) && (d_rt_tnew > d_tuse_rt);
    stall    = d_valid && (rs_late || rt_late || (d_md_use && md_busy));
    fwd_d_rs = (d_rs_tnew == '0) ? d_rs_hit : FWD_RF;
    fwd_d_rt = (d_rt_tnew == '0) ? d_rt_hit : FWD_RF;
    fwd_e_rs = e_rs_hit;
    fwd_e_rt = e_rt_hit;
    fwd_m_rt = slot_hits(w_q, m_rt_q);
  end

  always_comb begin
    w_d    = slot_age(m_q);
    m_d    = slot_age(e_q);
    m_rt_d = e_rt_q;
    if (stall) begin
      e_d    = '0;
      e_rs_d = '0;
      e_rt_d = '0;
    end else begin
      e_d    = '{valid: d_valid, waddr: d_waddr, tnew: d_tnew};
      e_rs_d = d_rs;
      e_rt_d = d_rt;
    end
    if (d_valid && d_md_start && !stall) begin
      cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage boundary: D -> E -> M -> W plus the HI/LO busy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= '0;
      e_rt_q <= '0;
      m_rt_q <= '0;
      cnt_q  <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
      m_rt_q <= m_rt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_waddr = '0;
  logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic       d_md_use = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0;
  logic       stall, fwd_m_rt, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_waddr(d_waddr), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Reference model: the last three instructions that entered E, youngest first,
  // each remembering the Tnew it had on entry; age in the list gives elapsed cycles.
  typedef struct {
    bit v;
    int waddr;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t pipe[$];
  int   busy = 0;

  function automatic int rem(int i);
    int r;
    r = pipe[i].tnew - i;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit hits(int i, int src);
    return pipe[i].v && pipe[i].waddr != 0 && pipe[i].waddr == src;
  endfunction

  function automatic int youngest(int src);
    for (int i = 0; i < 3; i++) if (hits(i, src)) return i;
    return -1;
  endfunction

  function automatic bit m_stall();
    int y;
    bit s;
    s = 0;
    if (!d_valid) return 0;
    y = youngest(int'(d_rs));
    if (y >= 0 && int'(d_tuse_rs) != 3 && rem(y) > int'(d_tuse_rs)) s = 1;
    y = youngest(int'(d_rt));
    if (y >= 0 && int'(d_tuse_rt) != 3 && rem(y) > int'(d_tuse_rt)) s = 1;
    if (d_md_use && busy > 0) s = 1;
    return s;
  endfunction

  function automatic int exp_fwd_d(int src);
    int y;
    y = youngest(src);
    if (y >= 0 && rem(y) == 0) return y + 1;
    return 0;
  endfunction

  function automatic int exp_fwd_e(int src);
    if (hits(1, src) && rem(1) == 0) return 2;
    if (hits(2, src)) return 3;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe = {};
      for (int i = 0; i < 3; i++) pipe.push_back('{0, 0, 0, 0, 0});
      busy = 0;
    end else begin
      bit   st;
      ent_t n;
      st = m_stall();
      if (st) n = '{0, 0, 0, 0, 0};
      else    n = '{d_valid, int'(d_waddr), int'(d_tnew), int'(d_rs), int'(d_rt)};
      if (d_valid && d_md_start && !st) busy = d_md_div ? 10 : 5;
      else if (busy > 0) busy--;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  end

  always @(negedge clk) begin
    if (pipe.size() == 3) begin
      bit st;
      st = m_stall();
      chk("stall", int'(stall), int'(st));
      chk("md_busy", int'(md_busy), int'(busy > 0));
      if (!st) begin
        chk("fwd_d_rs", int'(fwd_d_rs), exp_fwd_d(int'(d_rs)));
        chk("fwd_d_rt", int'(fwd_d_rt), exp_fwd_d(int'(d_rt)));
      end
      chk("fwd_e_rs", int'(fwd_e_rs), exp_fwd_e(pipe[0].rs));
      chk("fwd_e_rt", int'(fwd_e_rt), exp_fwd_e(pipe[0].rt));
      chk("fwd_m_rt", int'(fwd_m_rt), int'(hits(2, pipe[1].rt)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
    d_waddr = 0; d_tnew = 0; d_md_use = 0; d_md_start = 0; d_md_div = 0;
  endtask

  task automatic instr(int rs, int rt, int trs, int trt, int wa, int tn);
    d_valid = 1; d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
    d_waddr = 5'(wa); d_tnew = 2'(tn); d_md_use = 0; d_md_start = 0; d_md_div = 0;
  endtask

  task automatic md_wait(string name, int expect_cycles);
    int n;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      tick();
    end
    chk(name, n, expect_cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1;
    #2;
    chk("rst_stall", int'(stall), 0);
    chk("rst_busy", int'(md_busy), 0);
    chk("rst_fwd_e_rs", int'(fwd_e_rs), 0);
    chk("rst_fwd_m_rt", int'(fwd_m_rt), 0);
    tick(); tick();
    reset = 0;
    repeat (2) tick();

    // lw $1 ; addu $2,$1,$3
    instr(0, 0, 1, 3, 1, 2);
    @(negedge clk); chk("lw_nostall", int'(stall), 0); tick();
    instr(1, 3, 1, 1, 2, 1);
    @(negedge clk); chk("addu_stall_c1", int'(stall), 1); tick();
    @(negedge clk); chk("addu_stall_c2", int'(stall), 0);
    chk("addu_fwd_d_rs", int'(fwd_d_rs), 0); tick();
    idle();
    @(negedge clk); chk("addu_fwd_e_rs", int'(fwd_e_rs), 3); tick();
    repeat (3) tick();

    // lw $1 ; beq $1,$0
    instr(0, 0, 1, 3, 1, 2); tick();
    instr(1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("beq_stall_c1", int'(stall), 1); tick();
    @(negedge clk); chk("beq_stall_c2", int'(stall), 1); tick();
    @(negedge clk); chk("beq_stall_c3", int'(stall), 0);
    chk("beq_fwd_d_rs", int'(fwd_d_rs), 3); tick();
    idle(); repeat (3) tick();

    // jal ; jr $31
    instr(0, 0, 3, 3, 31, 0); tick();
    instr(31, 0, 0, 3, 0, 0);
    @(negedge clk); chk("jr_stall", int'(stall), 0);
    chk("jr_fwd_d_rs", int'(fwd_d_rs), 1); tick();
    idle(); repeat (3) tick();

    // ori $1 ; sw $1,0($4)
    instr(0, 0, 1, 3, 1, 1); tick();
    instr(4, 1, 1, 2, 0, 0);
    @(negedge clk); chk("sw_stall", int'(stall), 0); tick();
    idle();
    @(negedge clk); chk("sw_fwd_e_rt", int'(fwd_e_rt), 2); tick();
    @(negedge clk); chk("sw_fwd_m_rt", int'(fwd_m_rt), 1); tick();
    repeat (3) tick();

    // addu $0,... ; addu $5,$0,$0
    instr(1, 2, 1, 1, 0, 1); tick();
    instr(0, 0, 1, 1, 5, 1);
    @(negedge clk); chk("zero_stall", int'(stall), 0);
    chk("zero_fwd_d_rs", int'(fwd_d_rs), 0);
    chk("zero_fwd_d_rt", int'(fwd_d_rt), 0); tick();
    idle();
    @(negedge clk); chk("zero_fwd_e_rs", int'(fwd_e_rs), 0);
    chk("zero_fwd_e_rt", int'(fwd_e_rt), 0); tick();
    repeat (3) tick();

    // div ; mflo
    instr(0, 0, 3, 3, 0, 0); d_md_use = 1; d_md_start = 1; d_md_div = 1;
    @(negedge clk); chk("div_accept", int'(stall), 0); tick();
    instr(0, 0, 3, 3, 2, 1); d_md_use = 1;
    md_wait("div_stall_cycles", 10);
    chk("div_busy_done", int'(md_busy), 0); tick();
    idle(); repeat (2) tick();

    // mult ; mfhi
    instr(0, 0, 3, 3, 0, 0); d_md_use = 1; d_md_start = 1; d_md_div = 0; tick();
    instr(0, 0, 3, 3, 3, 1); d_md_use = 1;
    md_wait("mult_stall_cycles", 5);
    tick(); idle(); repeat (2) tick();

    // div, then reset while mflo is held off
    instr(0, 0, 3, 3, 0, 0); d_md_use = 1; d_md_start = 1; d_md_div = 1; tick();
    instr(0, 0, 3, 3, 2, 1); d_md_use = 1;
    @(negedge clk); chk("div_rst_pre_busy", int'(md_busy), 1); tick(); tick();
    reset = 1;
    #1;
    chk("div_rst_busy", int'(md_busy), 0);
    chk("div_rst_stall", int'(stall), 0);
    tick();
    reset = 0;
    idle(); repeat (2) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1; tick(); reset = 0;
      end
      d_valid    = ($urandom_range(0, 3) != 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_waddr    = 5'($urandom_range(0, 3));
      d_tnew     = 2'($urandom_range(0, 3));
      d_md_use   = ($urandom_range(0, 5) == 0);
      d_md_start = d_md_use && ($urandom_range(0, 1) == 1);
      d_md_div   = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's Tuse/Tnew decoder.
- Tracks destination register, remaining Tnew and source addresses for every in-flight instruction across the E/M/W stages.
- Generates the D-stage stall and the forwarding selects for D, E and M consumers.
- Adds a mult/div busy counter that stalls dependent instructions (mult/div/mfhi/mflo) while the HI/LO unit is occupied.

Parameters:
- REG_AW, 5, register address width; address 0 never creates a hazard.
- TW, 2, width of Tuse/Tnew fields.
- MULT_CYC, 5, busy cycles for a mult issue.
- DIV_CYC, 10, busy cycles for a div issue.
- CW, 4, busy counter width; must satisfy DIV_CYC < 2^CW.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- d_valid, in, 1, D-stage holds a real instruction.
- d_rs, in, REG_AW, D-stage rs address.
- d_rt, in, REG_AW, D-stage rt address.
- d_tuse_rs, in, TW, cycles until rs is needed; 3 means rs is unused.
- d_tuse_rt, in, TW, same for rt.
- d_waddr, in, REG_AW, destination register; 0 means no write.
- d_tnew, in, TW, cycles after entering E until the result exists.
- d_md_use, in, 1, D instruction needs HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- d_md_start, in, 1, D instruction is mult/div.
- d_md_div, in, 1, qualifies d_md_start: 1 = div, 0 = mult.
- stall, out, 1, freeze PC and D register; bubble into E.
- fwd_d_rs, out, 2, D-stage rs source: 0 = regfile, 1 = E, 2 = M, 3 = W.
- fwd_d_rt, out, 2, same encoding for D-stage rt.
- fwd_e_rs, out, 2, E-stage rs source: 0 = register, 2 = M, 3 = W.
- fwd_e_rt, out, 2, same encoding for E-stage rt.
- fwd_m_rt, out, 1, M-stage rt taken from W.
- md_busy, out, 1, HI/LO unit occupied.

Behaviour:
- Slot state: E, M and W slots, each holding {valid, waddr, tnew}. E also holds rs/rt; M also holds rt.
- Reset: all slots invalid, tnew = 0, busy counter = 0. All outputs 0 while reset is asserted. Reset mid-stall or mid-busy drops everything immediately.
- Advance (every clk edge): W <= M; M <= E with tnew = sat(tnew-1, 0).
- E on advance: if stall, E <= bubble (valid = 0). Otherwise E <= D fields with tnew = d_tnew, and valid = d_valid.
- Match, per stage: valid && waddr != 0 && waddr == src. The youngest matching stage (E > M > W) decides the result; older matches are ignored.
- Stall, combinational:
  - Asserted if d_valid and, for either source, the youngest match has tnew > tuse for that source.
  - Also asserted if d_valid && d_md_use && md_busy.
  - tuse = 3 never stalls.
- D forwarding: fwd_d_x = the youngest matching stage if its tnew == 0; otherwise 0. When stalled the value is don't-care.
- E forwarding: fwd_e_x compares E.rs/E.rt against M and W; M is chosen if M matches with tnew == 0, else W if W matches, else 0.
- M forwarding: fwd_m_rt = 1 when W matches M.rt.
- Busy counter:
  - Loaded on an edge where d_md_start && d_valid && !stall, with DIV_CYC if d_md_div else MULT_CYC.
  - Otherwise decrements when nonzero.
  - md_busy = (cnt != 0). A start is never accepted while busy, because stall blocks it.
- Simultaneous events: stall and a busy decrement occur in the same cycle; the counter is not frozen by stall.
- Decrement saturates, so tnew never wraps below 0.

Decomposition:
- Shared package: fwd select encodings (FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3), TUSE_NONE=3, the slot struct typedef {valid, waddr, tnew}, and default MULT_CYC/DIV_CYC.
- Sub-module hazard_match: one source address plus three slots -> {hit_stage, tnew_of_hit}. Instantiated for d_rs, d_rt, e_rs, e_rt.
- Busy counter lives inline.

Test Plan:
- lw $1 (tnew 2) then addu $2,$1,$3 (tuse 1, 1) -> stall = 1 for exactly 1 cycle. Next cycle stall = 0 and fwd_e_rs = 3 once addu reaches E.
- lw $1 then beq $1,$0 (tuse 0) -> stall for 2 cycles, then fwd_d_rs = 3.
- jal (waddr 31, tnew 0) then jr $31 (tuse 0) -> no stall; fwd_d_rs = 1 in the first cycle.
- ori $1 then sw $1,0($4) with rt tuse 2 -> no stall; the M-stage store receives fwd_m_rt = 1.
- div issued, then mflo -> md_busy stays 1 for 10 cycles and stall holds for 10 cycles. mult then mfhi -> 5 cycles. Reset asserted at cycle 3 of div -> md_busy = 0 and stall = 0 immediately.
- addu $0,... then addu $5,$0,$0 -> no stall; all fwd = 0.
